nvme_perf_sampler: RTL
======================

Name: nvme_perf_sampler

Overview:
Sits directly downstream of the NVMe performance event counter. Consumes its free-running active count, completion count and active-count summation, and takes periodic or on-demand snapshots. Each snapshot records per-interval deltas and the peak active count, and exposes them through a 1-cycle MMIO read port. Also owns the counter's clr_sum control for a software statistics clear.

Parameters:
sum_width, 64, width of sum/complete_cnt inputs and delta registers
active_width, 10, width of active_cnt input and peak register
timer_width, 32, width of interval timer and cfg_interval

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
active_cnt  in  active_width  current outstanding events from counter
complete_cnt  in  sum_width  free-running completion count from counter
sum  in  sum_width  free-running summation of active count from counter
clr_sum  out  1  one-cycle pulse to counter, clears sum/complete_cnt
cfg_interval  in  timer_width  sample period in cycles; 0 = periodic sampling off
snap_req  in  1  manual snapshot trigger pulse
stats_clr  in  1  software statistics clear pulse
rd_req  in  1  MMIO read request
rd_addr  in  3  register select
rd_ack  out  1  read acknowledge
rd_data  out  64  read data, valid only with rd_ack
snap_event  out  1  one-cycle pulse when a snapshot commits (S2)

Behaviour:
- Reset: all outputs 0; timer, prev_*, shadow_*, peak_run, seq, valid, missed and pipeline valids 0.
- Interval timer:
  - cfg_interval == 0: timer held at 0, no periodic triggers.
  - Otherwise it increments each cycle. When timer >= cfg_interval-1, it raises a trigger and reloads 0.
  - A >= compare means lowering cfg_interval below the current count triggers on the next cycle.
- Trigger = timer expiry OR snap_req. Coincident sources in one cycle produce one snapshot.
- Blocked cycles: triggers are ignored, and the timer keeps counting, in any cycle where stats_clr or clr_sum is high.
- Pipeline, fully pipelined, no stall; a trigger every cycle gives a snapshot every cycle:
  - T (trigger cycle): shadow_peak_next = max(peak_run, active_cnt); peak_run <= active_cnt. Cycle T counts toward both intervals.
  - S1 (T+1): register cur_sum <= sum and cur_cmp <= complete_cnt, as sampled at T.
  - S2 (T+2): delta_sum <= cur_sum - prev_sum and delta_cmp <= cur_cmp - prev_cmp, modulo 2^sum_width so counter wrap is exact. Also prev <= cur, shadow_peak commits, seq increments (32-bit, wraps), snap_event pulses.
- Non-trigger cycles: peak_run <= max(peak_run, active_cnt).
- valid/missed:
  - S2 sets valid.
  - If valid is already 1 at S2, missed increments, saturating at 16'hFFFF.
- Status read (addr 4): returns the pre-update value, then clears valid and missed.
  - Status read coincident with S2: result is valid=1, missed=0.
- stats_clr:
  - clr_sum is a registered copy, asserted the cycle after stats_clr.
  - In the stats_clr cycle, zero prev_*, shadow_*, peak_run, seq, valid, missed and timer, and flush S1/S2 (in-flight snapshot discarded, no snap_event).
  - Post-clear deltas are therefore relative to the counter's zeroed values.
- MMIO read:
  - rd_ack is asserted the cycle after rd_req; back-to-back requests are allowed.
  - rd_data is 0 when rd_ack is low.
  - Register map: 0 delta_sum (zero-extended), 1 delta_cmp, 2 shadow_peak (zero-extended), 3 seq (zero-extended), 4 status {valid[16], missed[15:0]}, 5-7 read 0.
  - Reads of addrs 0-3 coincident with S2 return pre-update values.

Decomposition:
- Package nvme_perf_pkg holds:
  - register address localparams (PERF_DSUM=0, PERF_DCMP=1, PERF_PEAK=2, PERF_SEQ=3, PERF_STAT=4);
  - status bit positions;
  - missed-counter width (16) and seq width (32).
- Sub-module nvme_perf_interval_timer: timer, >= compare, reload, enable on cfg_interval != 0. Output is a trigger pulse.

Test Plan:
1. Periodic delta: cfg_interval=100, active_cnt held at 3, complete_cnt +1 every 10 cycles.
   - Snapshots commit every 100 cycles.
   - Second snapshot reads delta_sum=300, delta_cmp=10, peak=3, seq=2.
2. Wrap: sum preloaded to 2^64-50, cfg_interval=0, snap_req, then sum advances 80, then snap_req.
   - Second snapshot delta_sum=80.
3. Peak/simultaneous: active_cnt pulses to 700 for one cycle mid-interval; snap_req and timer expiry in the same cycle.
   - Exactly one snapshot, peak=700.
   - Next interval peak equals the active_cnt at the trigger cycle.
4. Missed: three snapshots without a status read.
   - addr 4 reads valid=1, missed=2; a subsequent read returns 0.
   - Status read coincident with S2 yields valid=1, missed=0 afterwards.
5. Clear: stats_clr with a snapshot in S1.
   - clr_sum high exactly one cycle later.
   - No snap_event; seq=0.
   - Triggers in the stats_clr/clr_sum cycles are ignored.
6. Reset mid-operation: assert reset during S2 and a pending read.
   - rd_ack, clr_sum and snap_event are 0 immediately; all registers read 0 after reset.

Source files
------------

// File: rtl/nvme_perf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nvme_perf_pkg : register map and field widths for the perf snapshot sampler
// Rev 1.0
// ---------------------------------------------------------------------------
package nvme_perf_pkg;

  typedef logic [2:0] perf_addr_t;

  localparam perf_addr_t PERF_DSUM = 3'd0;
  localparam perf_addr_t PERF_DCMP = 3'd1;
  localparam perf_addr_t PERF_PEAK = 3'd2;
  localparam perf_addr_t PERF_SEQ  = 3'd3;
  localparam perf_addr_t PERF_STAT = 3'd4;

  localparam int STAT_VALID_BIT  = 16;
  localparam int STAT_MISSED_LSB = 0;
  localparam int MISSED_W        = 16;
  localparam int SEQ_W           = 32;

  function automatic logic [MISSED_W-1:0] missed_inc(input logic [MISSED_W-1:0] m);
    return (m == {MISSED_W{1'b1}}) ? m : m + MISSED_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nvme_perf_interval_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nvme_perf_interval_timer : free-running period timer, pulses o_expire once per period
// Rev 1.0
// ---------------------------------------------------------------------------
module nvme_perf_interval_timer #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic [TIMER_WIDTH-1:0] i_cfg_interval,
  output logic                   o_expire
);

  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_last;
  logic                   w_en;
  logic                   w_hit;

  assign w_en   = |i_cfg_interval;
  assign w_last = i_cfg_interval - TIMER_WIDTH'(1);
  // >= so that shrinking the interval below the running count fires at once
  assign w_hit  = w_en && (r_timer >= w_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (i_clear || !w_en || w_hit) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_WIDTH'(1);
    end
  end

  assign o_expire = w_hit;

endmodule
`default_nettype wire

// File: rtl/nvme_perf_sampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nvme_perf_sampler : periodic/on-demand snapshot of perf counter deltas and peak, MMIO readable
// Rev 1.0
// ---------------------------------------------------------------------------
module nvme_perf_sampler
  import nvme_perf_pkg::*;
#(
  parameter int SUM_WIDTH    = 64,
  parameter int ACTIVE_WIDTH = 10,
  parameter int TIMER_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ACTIVE_WIDTH-1:0] i_active_cnt,
  input  logic [SUM_WIDTH-1:0]    i_complete_cnt,
  input  logic [SUM_WIDTH-1:0]    i_sum,
  output logic                    o_clr_sum,
  input  logic [TIMER_WIDTH-1:0]  i_cfg_interval,
  input  logic                    i_snap_req,
  input  logic                    i_stats_clr,
  input  logic                    i_rd_req,
  input  logic [2:0]              i_rd_addr,
  output logic                    o_rd_ack,
  output logic [63:0]             o_rd_data,
  output logic                    o_snap_event
);

  logic                    w_expire;
  logic                    w_block;
  logic                    w_trig;
  logic                    w_stat_rd;
  logic [ACTIVE_WIDTH-1:0] w_peak_next;
  logic [63:0]             w_rd_mux;
  perf_addr_t              w_addr;

  logic                    r_clr_sum;
  logic                    r_rd_ack;
  logic [63:0]             r_rd_data;
  logic                    r_snap_event;
  logic [ACTIVE_WIDTH-1:0] r_peak_run;

  logic                    r_s1_vld;
  logic [SUM_WIDTH-1:0]    r_cur_sum;
  logic [SUM_WIDTH-1:0]    r_cur_cmp;
  logic [ACTIVE_WIDTH-1:0] r_s1_peak;

  logic [SUM_WIDTH-1:0]    r_prev_sum;
  logic [SUM_WIDTH-1:0]    r_prev_cmp;
  logic [SUM_WIDTH-1:0]    r_dsum;
  logic [SUM_WIDTH-1:0]    r_dcmp;
  logic [ACTIVE_WIDTH-1:0] r_peak;
  logic [SEQ_W-1:0]        r_seq;
  logic                    r_valid;
  logic [MISSED_W-1:0]     r_missed;

  nvme_perf_interval_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (i_stats_clr),
    .i_cfg_interval (i_cfg_interval),
    .o_expire       (w_expire)
  );

  // Triggers are dropped while the counter is being cleared so no snapshot straddles the clear
  assign w_block     = i_stats_clr | r_clr_sum;
  assign w_trig      = (w_expire | i_snap_req) & ~w_block;
  assign w_peak_next = (i_active_cnt > r_peak_run) ? i_active_cnt : r_peak_run;
  assign w_addr      = i_rd_addr;
  assign w_stat_rd   = i_rd_req && (w_addr == PERF_STAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_sum  <= 1'b0;
      r_peak_run <= '0;
      r_s1_vld   <= 1'b0;
      r_cur_sum  <= '0;
      r_cur_cmp  <= '0;
      r_s1_peak  <= '0;
    end else begin
      r_clr_sum <= i_stats_clr;
      if (i_stats_clr) begin
        r_peak_run <= '0;
        r_s1_vld   <= 1'b0;
      end else begin
        r_peak_run <= w_trig ? i_active_cnt : w_peak_next;
        r_s1_vld   <= w_trig;
        if (w_trig) begin
          r_cur_sum <= i_sum;
          r_cur_cmp <= i_complete_cnt;
          r_s1_peak <= w_peak_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_event <= 1'b0;
      r_prev_sum   <= '0;
      r_prev_cmp   <= '0;
      r_dsum       <= '0;
      r_dcmp       <= '0;
      r_peak       <= '0;
      r_seq        <= '0;
      r_valid      <= 1'b0;
      r_missed     <= '0;
    end else if (i_stats_clr) begin
      r_snap_event <= 1'b0;
      r_prev_sum   <= '0;
      r_prev_cmp   <= '0;
      r_dsum       <= '0;
      r_dcmp       <= '0;
      r_peak       <= '0;
      r_seq        <= '0;
      r_valid      <= 1'b0;
      r_missed     <= '0;
    end else begin
      r_snap_event <= r_s1_vld;
      if (r_s1_vld) begin
        r_dsum     <= r_cur_sum - r_prev_sum;
        r_dcmp     <= r_cur_cmp - r_prev_cmp;
        r_prev_sum <= r_cur_sum;
        r_prev_cmp <= r_cur_cmp;
        r_peak     <= r_s1_peak;
        r_seq      <= r_seq + SEQ_W'(1);
        r_valid    <= 1'b1;
        // A status read in the commit cycle consumed the old state; this snapshot starts fresh
        if (w_stat_rd) begin
          r_missed <= '0;
        end else if (r_valid) begin
          r_missed <= missed_inc(r_missed);
        end
      end else if (w_stat_rd) begin
        r_valid  <= 1'b0;
        r_missed <= '0;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      PERF_DSUM: w_rd_mux = 64'(r_dsum);
      PERF_DCMP: w_rd_mux = 64'(r_dcmp);
      PERF_PEAK: w_rd_mux = 64'(r_peak);
      PERF_SEQ:  w_rd_mux = 64'(r_seq);
      PERF_STAT: begin
        w_rd_mux[STAT_VALID_BIT]                 = r_valid;
        w_rd_mux[STAT_MISSED_LSB +: MISSED_W]    = r_missed;
      end
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack  <= i_rd_req;
      r_rd_data <= i_rd_req ? w_rd_mux : 64'd0;
    end
  end

  assign o_clr_sum    = r_clr_sum;
  assign o_rd_ack     = r_rd_ack;
  assign o_rd_data    = r_rd_data;
  assign o_snap_event = r_snap_event;

endmodule
`default_nettype wire
